key_debounce: RTL

- Sits between the keypad matrix scanner and the CPU.
- Synchronises and debounces the 16 raw CHIP-8 key levels and drives a clean `keys` bus to the CPU.
- Also emits ordered press/release events through a small FIFO with a valid/ack handshake. The CPU's wait-for-key instruction (FX0A) consumes these events instead of polling levels.

---
 rtl/chip8_pkg.sv | 14 +
 rtl/key_event_fifo.sv | 48 ++++
 rtl/key_debounce.sv | 113 +++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared key and event definitions for the CHIP-8 keypad path.
// Event layout: bit 4 = pressed, bits 3:0 = key index.
package chip8_pkg;
  localparam int KEY_COUNT      = 16;
  localparam int KEY_IDX_W      = 4;
  localparam int EV_W           = 5;
  localparam int EV_PRESSED_BIT = 4;
  localparam int EV_KEY_LSB     = 0;

  typedef struct packed {
    logic                 pressed;
    logic [KEY_IDX_W-1:0] key;
  } key_ev_t;
endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous event FIFO; head is combinational from the read pointer, reads 0 when empty.
// Push is dropped when full (full is judged before any same-cycle pop); pop while empty is ignored.
module key_event_fifo
  import chip8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [EV_W-1:0] din,
  output logic            full,
  input  logic            pop,
  output logic [EV_W-1:0] dout,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EV_W-1:0] mem_q [DEPTH];
  logic [EV_W-1:0] mem_d [DEPTH];
  logic            do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
    dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/key_debounce.sv
// Synchronises and debounces 16 key levels and queues ordered press/release events.
// keys follow raw after 2 sync flops + STABLE_COUNT sample ticks; events wait in pending when the FIFO is full.
module key_debounce
  import chip8_pkg::*;
#(
  parameter int CLK_FREQ     = 16_000_000,
  parameter int SAMPLE_HZ    = 1000,
  parameter int STABLE_COUNT = 8,
  parameter int DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_COUNT-1:0] keys_raw,
  output logic [KEY_COUNT-1:0] keys,
  output logic                 ev_valid,
  output logic [KEY_IDX_W-1:0] ev_key,
  output logic                 ev_pressed,
  input  logic                 ev_ack,
  output logic                 overflow,
  input  logic                 overflow_clr
);
  localparam int DIV = CLK_FREQ / SAMPLE_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(STABLE_COUNT);

  logic [KEY_COUNT-1:0] sync1_q, sync2_q;
  logic [KEY_COUNT-1:0] keys_q, keys_d, pending_q, pending_d;
  logic [KEY_COUNT-1:0] set_mask, clr_mask;
  logic [PW-1:0]        presc_q, presc_d;
  logic [CW-1:0]        cnt_q [KEY_COUNT];
  logic [CW-1:0]        cnt_d [KEY_COUNT];
  logic                 overflow_q, overflow_d;
  logic                 tick, push, fifo_full, fifo_empty;
  logic [KEY_IDX_W-1:0] sel_idx;
  key_ev_t              push_ev, head_ev;

  always_comb begin
    tick    = (presc_q == PW'(DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // A change is accepted only after STABLE_COUNT consecutive differing samples.
  always_comb begin
    keys_d   = keys_q;
    cnt_d    = cnt_q;
    set_mask = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (tick) begin
        if (sync2_q[i] == keys_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(STABLE_COUNT - 1)) begin
          keys_d[i]   = ~keys_q[i];
          cnt_d[i]    = '0;
          set_mask[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Lowest pending index wins; a new set on another key survives this cycle's clear.
  always_comb begin
    sel_idx = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = KEY_IDX_W'(i);
    end
    push     = (|pending_q) && !fifo_full;
    clr_mask = '0;
    if (push) clr_mask[sel_idx] = 1'b1;
    push_ev.key     = sel_idx;
    push_ev.pressed = keys_q[sel_idx];
    pending_d  = (pending_q | set_mask) & ~clr_mask;
    overflow_d = (|(set_mask & pending_q)) | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      keys_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < KEY_COUNT; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= keys_raw;
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      keys_q     <= keys_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ev),
    .full  (fifo_full),
    .pop   (ev_ack),
    .dout  (head_ev),
    .empty (fifo_empty)
  );

  assign keys       = keys_q;
  assign overflow   = overflow_q;
  assign ev_valid   = !fifo_empty;
  assign ev_key     = head_ev.key;
  assign ev_pressed = head_ev.pressed;
endmodule
